// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the CPU MEM stage and a DMA/loader port.
// Optional DMA starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_gnt,
  output logic              mem_WE,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_CPU, S_DMA} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [BW-1:0] beat_num;
  logic          force_dma;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  assign force_dma = dma_req && (wait_cnt_q == WW'(MAX_WAIT));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dma_req || dma_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  // Grants are combinational so the winner sees the memory with no added latency.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      if (state_q == S_DMA) begin
        dma_gnt = dma_req;
      end else if (force_dma) begin
        dma_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_WE    = 1'b0;
    mem_A     = '0;
    mem_WD    = '0;
    cpu_rdata = '0;
    dma_rdata = '0;
    if (cpu_gnt) begin
      mem_WE    = cpu_we;
      mem_A     = cpu_addr;
      mem_WD    = cpu_wdata;
      cpu_rdata = mem_RD;
    end else if (dma_gnt) begin
      mem_WE    = dma_we;
      mem_A     = dma_addr;
      mem_WD    = dma_wdata;
      dma_rdata = mem_RD;
    end
  end

  // beat_num is the ordinal of the beat granted this cycle within a locked burst.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    beat_num    = (burst_cnt_q < BW'(MAX_BURST)) ? burst_cnt_q + 1'b1 : burst_cnt_q;
    if (state_q == S_CPU) begin
      burst_cnt_d = '0;
      if (dma_gnt && dma_lock && (MAX_BURST > 1)) begin
        state_d     = S_DMA;
        burst_cnt_d = BW'(1);
      end
    end else begin
      if (dma_req && dma_lock && (beat_num < BW'(MAX_BURST))) begin
        burst_cnt_d = beat_num;
      end else begin
        state_d     = S_CPU;
        burst_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CPU;
      burst_cnt_q <= '0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 8;
  localparam int MW = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_gnt, cpu_stall;
  logic          dma_req, dma_we, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_gnt;
  logic          mem_WE;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD, mem_RD;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // Memory instance: async read, write on posedge.
  logic [DW-1:0] tb_mem [256];
  assign mem_RD = tb_mem[mem_A[7:0]];
  always @(posedge clk) if (mem_WE) tb_mem[mem_A[7:0]] <= mem_WD;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the memory, how many beats of the current burst are done,
  // how long DMA has waited, and the expected memory contents.
  logic [DW-1:0] ref_mem [256];
  bit in_burst   = 1'b0;
  int beats_done = 0;
  int starve     = 0;
  bit m_cpu_gnt  = 1'b0;
  bit m_dma_gnt  = 1'b0;

  always @(negedge clk) begin
    bit            ec, ed, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, ecr, edr;
    ec = 1'b0;
    ed = 1'b0;
    if (!rst) begin
      if (in_burst) ed = dma_req;
      else if (GUARD && dma_req && starve >= MW) ed = 1'b1;
      else begin
        ec = cpu_req;
        ed = dma_req && !cpu_req;
      end
    end
    ewe = ec ? cpu_we : (ed ? dma_we : 1'b0);
    ea  = ec ? cpu_addr : (ed ? dma_addr : '0);
    ewd = ec ? cpu_wdata : (ed ? dma_wdata : '0);
    ecr = ec ? ref_mem[cpu_addr[7:0]] : '0;
    edr = ed ? ref_mem[dma_addr[7:0]] : '0;
    chk("cpu_gnt", cpu_gnt, ec);
    chk("dma_gnt", dma_gnt, ed);
    chk("cpu_stall", cpu_stall, cpu_req && !ec);
    chk("mem_WE", mem_WE, ewe);
    chk("mem_A", mem_A, ea);
    chk("mem_WD", mem_WD, ewd);
    chk("cpu_rdata", cpu_rdata, ecr);
    chk("dma_rdata", dma_rdata, edr);
    m_cpu_gnt = ec;
    m_dma_gnt = ed;
    if (rst) begin
      in_burst   = 1'b0;
      beats_done = 0;
      starve     = 0;
    end else begin
      if (ewe) ref_mem[ea[7:0]] = ewd;
      if (in_burst) begin
        beats_done++;
        if (!(dma_req && dma_lock && beats_done < MB)) begin
          in_burst   = 1'b0;
          beats_done = 0;
        end
      end else if (ed && dma_lock && MB > 1) begin
        in_burst   = 1'b1;
        beats_done = 1;
      end
      starve = (ed || !dma_req) ? 0 : ((starve < MW) ? starve + 1 : MW);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    idle();
    // Reset with both requesters asking to write
    rst = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 32'h1234;
    dma_req = 1; dma_we = 1; dma_addr = 6; dma_wdata = 32'h5678;
    @(negedge clk);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_mem_WE", mem_WE, 0);
    chk("rst_cpu_stall", cpu_stall, 1);
    next();
    @(negedge clk);
    chk("rst_mem5", tb_mem[5], 0);
    $display("reset: grants held low, memory untouched");

    // CPU store then load
    next(); rst = 0; idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 32'hDEAD;
    @(negedge clk);
    chk("st_cpu_gnt", cpu_gnt, 1);
    chk("st_cpu_stall", cpu_stall, 0);
    next(); cpu_we = 0; cpu_wdata = '0;
    @(negedge clk);
    chk("ld_cpu_rdata", cpu_rdata, 32'hDEAD);
    chk("ld_cpu_stall", cpu_stall, 0);
    $display("cpu store/load addr 5 -> %0h", cpu_rdata);

    // Contention in S_CPU
    next(); dma_req = 1; dma_we = 0; dma_addr = 5;
    @(negedge clk);
    chk("cont_cpu_gnt", cpu_gnt, 1);
    chk("cont_dma_gnt", dma_gnt, 0);
    next(); cpu_req = 0;
    @(negedge clk);
    chk("cont_dma_gnt2", dma_gnt, 1);
    chk("cont_dma_rdata", dma_rdata, 32'hDEAD);
    $display("contention: cpu first, dma after cpu drops");

    // Locked burst of MAX_BURST writes, CPU joins on beat 2
    for (int i = 1; i <= MB; i++) begin
      next(); idle();
      dma_req = 1; dma_we = 1; dma_lock = 1;
      dma_addr = 200 + i - 1; dma_wdata = 32'h100 + i - 1;
      if (i >= 2) cpu_req = 1;
      @(negedge clk);
      chk("burst_dma_gnt", dma_gnt, 1);
      if (i >= 2) chk("burst_cpu_stall", cpu_stall, 1);
    end
    next(); dma_addr = 250; dma_wdata = 32'hBAD;
    @(negedge clk);
    chk("release_cpu_gnt", cpu_gnt, 1);
    chk("release_dma_gnt", dma_gnt, 0);
    next(); idle();
    @(negedge clk);
    for (int i = 0; i < MB; i++) chk("burst_mem", tb_mem[200 + i], 32'h100 + i);
    chk("burst_no_extra", tb_mem[250], 0);
    $display("burst: %0d beats written to 200..%0d", MB, 200 + MB - 1);

    // Reset during beat 3 of a burst
    for (int i = 1; i <= 3; i++) begin
      next(); idle();
      dma_req = 1; dma_we = 1; dma_lock = 1;
      dma_addr = 220 + i - 1; dma_wdata = 32'h200 + i - 1;
      rst = (i == 3);
      @(negedge clk);
      chk("rstb_dma_gnt", dma_gnt, (i != 3));
      if (i == 3) chk("rstb_mem_WE", mem_WE, 0);
    end
    next(); rst = 0; idle();
    cpu_req = 1; cpu_addr = 220;
    @(negedge clk);
    chk("rstb_cpu_gnt", cpu_gnt, 1);
    chk("rstb_cpu_rdata", cpu_rdata, 32'h200);
    chk("rstb_mem221", tb_mem[221], 32'h201);
    chk("rstb_mem222", tb_mem[222], 0);
    $display("reset mid-burst: beats 1-2 kept, beat 3 dropped");

    // Starvation under continuous cpu_req
    next(); idle();
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      next(); cpu_req = 1; cpu_addr = 1; dma_req = 1; dma_addr = 2;
      @(negedge clk);
      chk("starve_dma_gnt", dma_gnt, GUARD && i == 5);
      chk("starve_cpu_gnt", cpu_gnt, !(GUARD && i == 5));
    end
    $display("starvation: guard=%0d", GUARD);

    // Randomized traffic; ungranted requesters hold their request steady
    next(); idle();
    for (int n = 0; n < 2000; n++) begin
      next();
      rst = ($urandom_range(0, 99) == 0);
      if (!(cpu_req && !m_cpu_gnt)) begin
        cpu_req   = $urandom_range(0, 1);
        cpu_we    = $urandom_range(0, 1);
        cpu_addr  = $urandom_range(0, 255);
        cpu_wdata = $urandom;
      end
      if (!(dma_req && !m_dma_gnt)) begin
        dma_req   = $urandom_range(0, 2) != 0;
        dma_we    = $urandom_range(0, 1);
        dma_lock  = $urandom_range(0, 9) < 8;
        dma_addr  = $urandom_range(0, 255);
        dma_wdata = $urandom;
      end
    end
    next(); idle(); rst = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) chk("final_mem", tb_mem[i], ref_mem[i]);
    $display("random: 2000 cycles of mixed traffic");
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
